pla_exhaustive_tester: RTL

- Sequential harness that drives an N-input single-output combinational benchmark circuit (PLA-derived, mockturtle-optimised) through all 2^N input vectors.
- Reads the circuit's output on every vector and compacts the responses into an ON-set count and a MISR signature.
- Sits on the opposite side of the netlist interface: this block is the driver of x0..x(N-1) and the reader of y0.
- Used to compare original and autosymmetry-reconstructed netlists in silicon or emulation.

---
 rtl/pla_exhaustive_tester.sv | 100 ++++++++++
 1 files changed

// File: rtl/pla_exhaustive_tester.sv
// Exhaustive sweep harness for an N_IN-input, single-output netlist.
// Drives x_out through every vector, then compacts y_in into a count and a MISR.
// Ports: clk, rst_n (async low), start, expected_ones -> x_out, busy, done,
//        ones_count, signature, match; y_in is the netlist output y0.
module pla_exhaustive_tester #(
  parameter int          N_IN   = 9,
  parameter int          SETTLE = 1,
  parameter int          SIG_W  = 16,
  parameter logic [31:0] POLY   = 32'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_IN:0]     expected_ones,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     ones_count,
  output logic [SIG_W-1:0]  signature,
  output logic              match
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [SIG_W-1:0] L_POLY = POLY[SIG_W-1:0];
  localparam logic [3:0]       L_LAST = 4'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [N_IN-1:0]  r_x;
  logic [N_IN:0]    r_ones;
  logic [SIG_W-1:0] r_sig;
  logic             r_busy;
  logic             r_done;

  logic [SIG_W-1:0] w_sig_nxt;
  logic             w_last;

  // Galois-style MISR step with y_in folded into bit 0
  assign w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? L_POLY : '0)
                   ^ SIG_W'(y_in);
  assign w_last = &r_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_ones  <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_ones  <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == L_LAST) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_ones <= r_ones + (N_IN+1)'(y_in);
          r_sig  <= w_sig_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_DRIVE;
            r_x     <= r_x + N_IN'(1);
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_out      = r_x;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ones_count = r_ones;
  assign signature  = r_sig;
  assign match      = r_done && (r_ones == expected_ones);

endmodule
